// File: rtl/seq_shift_unit_32bit_if.sv
// Controller-side bundle for the sequential shift unit: request fields and handshake/result.
interface seq_shift_unit_32bit_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned AMT_W = 5
);
    logic             start;
    logic [WIDTH-1:0] D;
    logic [AMT_W-1:0] amt;
    logic             C;
    logic [1:0]       mode;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] S;

    modport master (
        output start, D, amt, C, mode,
        input  ready, busy, done, S
    );

    modport slave (
        input  start, D, amt, C, mode,
        output ready, busy, done, S
    );
endinterface

// File: rtl/seq_shift_unit_32bit.sv
// Multi-cycle shift/rotate engine with start/busy/done handshake.
// Define SHIFT_FAST2_EN to advance two positions per cycle while at least two remain.
module seq_shift_unit_32bit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned AMT_W = 5
) (
    input logic                  clk,
    input logic                  rst,
    seq_shift_unit_32bit_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic [1:0]       mode_q, mode_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             accept;
    logic             shift_last;

    // One position; mode 11 falls through to logical, arithmetic left equals logical left.
    function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] x, input logic left,
                                              input logic [1:0] md);
        logic fill;
        if (left) begin
            fill = (md == 2'b10) ? x[WIDTH-1] : 1'b0;
            return {x[WIDTH-2:0], fill};
        end
        unique case (md)
            2'b01:   fill = x[WIDTH-1];
            2'b10:   fill = x[0];
            default: fill = 1'b0;
        endcase
        return {fill, x[WIDTH-1:1]};
    endfunction

    assign accept = bus.start && (state_q != StShift);

`ifdef SHIFT_FAST2_EN
    assign shift_last = (cnt_q <= AMT_W'(2));
`else
    assign shift_last = (cnt_q == AMT_W'(1));
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            sh_q    <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            mode_q  <= 2'b00;
            s_q     <= '0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            mode_q  <= mode_d;
            s_q     <= s_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (bus.start) state_d = (bus.amt == '0) ? StDone : StShift;
            end
            StShift: if (shift_last) state_d = StDone;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        sh_d   = sh_q;
        cnt_d  = cnt_q;
        dir_d  = dir_q;
        mode_d = mode_q;
        s_d    = s_q;
        if (accept) begin
            sh_d   = bus.D;
            cnt_d  = bus.amt;
            dir_d  = bus.C;
            mode_d = bus.mode;
            if (bus.amt == '0) s_d = bus.D;
        end else if (state_q == StShift) begin
`ifdef SHIFT_FAST2_EN
            if (cnt_q >= AMT_W'(2)) begin
                sh_d  = step(step(sh_q, dir_q, mode_q), dir_q, mode_q);
                cnt_d = cnt_q - AMT_W'(2);
            end else begin
                sh_d  = step(sh_q, dir_q, mode_q);
                cnt_d = cnt_q - AMT_W'(1);
            end
`else
            sh_d  = step(sh_q, dir_q, mode_q);
            cnt_d = cnt_q - AMT_W'(1);
`endif
            if (shift_last) s_d = sh_d;
        end
    end

    always_comb begin
        bus.ready = (state_q != StShift);
        bus.busy  = (state_q == StShift);
        bus.done  = (state_q == StDone);
        bus.S     = s_q;
    end

endmodule

// File: tb/tb_seq_shift_unit_32bit.sv
// Bench for seq_shift_unit_32bit: cycle-count reference model, directed literals, random ops.
module tb_seq_shift_unit_32bit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seq_shift_unit_32bit_if bus_if ();

    seq_shift_unit_32bit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

`ifdef SHIFT_FAST2_EN
    localparam bit Fast = 1'b1;
`else
    localparam bit Fast = 1'b0;
`endif

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_shift(input logic [31:0] d, input int a, input logic left,
                                              input logic [1:0] m);
        logic [63:0]        dd;
        logic signed [31:0] sd;
        dd = {d, d};
        sd = d;
        if (m == 2'b10) begin
            if (left) begin
                dd = dd << a;
                return dd[63:32];
            end
            dd = dd >> a;
            return dd[31:0];
        end
        if (left) return d << a;
        if (m == 2'b01) return 32'(sd >>> a);
        return d >> a;
    endfunction

    // Shift cycles spent busy for a given amount.
    function automatic int cyc(input int a);
        return Fast ? (a + 1) / 2 : a;
    endfunction

    logic        m_valid = 1'b0;
    logic        m_busy, m_done;
    logic [31:0] m_s, m_pend;
    int          m_rem;

    always @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b1;
            m_busy  <= 1'b0;
            m_done  <= 1'b0;
            m_s     <= '0;
            m_rem   <= 0;
        end else if (m_busy) begin
            m_done <= 1'b0;
            if (m_rem == 1) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
                m_s    <= m_pend;
            end
            m_rem <= m_rem - 1;
        end else begin
            m_done <= 1'b0;
            if (bus_if.start) begin
                m_pend <= ref_shift(bus_if.D, int'(bus_if.amt), bus_if.C, bus_if.mode);
                if (cyc(int'(bus_if.amt)) == 0) begin
                    m_done <= 1'b1;
                    m_s    <= ref_shift(bus_if.D, int'(bus_if.amt), bus_if.C, bus_if.mode);
                end else begin
                    m_busy <= 1'b1;
                    m_rem  <= cyc(int'(bus_if.amt));
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("model ready", 32'(bus_if.ready), 32'(!m_busy));
            check("model busy", 32'(bus_if.busy), 32'(m_busy));
            check("model done", 32'(bus_if.done), 32'(m_done));
            check("model S", bus_if.S, m_s);
        end
    end

    // Caller is at a negedge; returns at the negedge of the done cycle.
    task automatic do_op(input logic [31:0] d, input logic [4:0] a, input logic c,
                         input logic [1:0] m, input logic [31:0] exp_s, input int exp_lat,
                         input bit poke, input string name);
        int n;
        int nbusy;
        bit got;
        bus_if.start = 1'b1;
        bus_if.D     = d;
        bus_if.amt   = a;
        bus_if.C     = c;
        bus_if.mode  = m;
        n     = 0;
        nbusy = 0;
        got   = 1'b0;
        while (!got && n < 100) begin
            @(negedge clk);
            n++;
            if (bus_if.done) got = 1'b1;
            if (bus_if.busy) nbusy++;
            bus_if.start = !got && poke && (n == 3);
            bus_if.D     = $urandom;
            bus_if.amt   = 5'($urandom);
            bus_if.C     = 1'($urandom);
            bus_if.mode  = 2'($urandom);
        end
        check({name, " done seen"}, 32'(got), 32'd1);
        check({name, " latency"}, 32'(n), 32'(exp_lat));
        check({name, " busy cycles"}, 32'(nbusy), 32'(exp_lat - 1));
        check({name, " S"}, bus_if.S, exp_s);
    endtask

    initial begin
        int cnt;
        logic [31:0] d;
        logic [4:0]  a;
        logic        c;
        logic [1:0]  m;
        bus_if.start = 1'b0;
        bus_if.D     = '0;
        bus_if.amt   = '0;
        bus_if.C     = 1'b0;
        bus_if.mode  = 2'b00;
        repeat (2) @(negedge clk);
        check("reset ready", 32'(bus_if.ready), 32'd1);
        check("reset busy", 32'(bus_if.busy), 32'd0);
        check("reset done", 32'(bus_if.done), 32'd0);
        check("reset S", bus_if.S, 32'h0);
        rst = 1'b0;

        do_op(32'h0000_0001, 5'd31, 1'b1, 2'b00, 32'h8000_0000, Fast ? 17 : 32, 1'b0, "sll31");
        @(negedge clk);
        do_op(32'h8000_0000, 5'd4, 1'b0, 2'b01, 32'hF800_0000, Fast ? 3 : 5, 1'b0, "sra4");
        @(negedge clk);
        do_op(32'hF000_000F, 5'd4, 1'b0, 2'b00, 32'h0F00_0000, Fast ? 3 : 5, 1'b0, "srl4");
        @(negedge clk);
        do_op(32'h8000_0001, 5'd1, 1'b1, 2'b10, 32'h0000_0003, 2, 1'b0, "rol1");
        @(negedge clk);
        do_op(32'h8000_0001, 5'd1, 1'b0, 2'b10, 32'hC000_0000, 2, 1'b0, "ror1");
        @(negedge clk);
        do_op(32'h8000_0000, 5'd4, 1'b0, 2'b11, 32'h0800_0000, Fast ? 3 : 5, 1'b0, "mode11");
        @(negedge clk);
        do_op(32'h1234_5678, 5'd0, 1'b0, 2'b00, 32'h1234_5678, 1, 1'b0, "amt0");
        do_op(32'h0000_0010, 5'd2, 1'b0, 2'b00, 32'h0000_0004, Fast ? 2 : 3, 1'b0, "b2b");
        @(negedge clk);
        do_op(32'h0000_00F0, 5'd10, 1'b1, 2'b00, 32'h0003_C000, Fast ? 6 : 11, 1'b1, "ignored");
        cnt = 0;
        repeat (15) begin
            @(negedge clk);
            if (bus_if.done) cnt++;
        end
        check("ignored extra done", 32'(cnt), 32'd0);

        bus_if.start = 1'b1;
        bus_if.D     = 32'hFFFF_FFFF;
        bus_if.amt   = 5'd20;
        bus_if.C     = 1'b1;
        bus_if.mode  = 2'b00;
        @(negedge clk);
        bus_if.start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort S", bus_if.S, 32'h0);
        check("abort busy", 32'(bus_if.busy), 32'd0);
        check("abort done", 32'(bus_if.done), 32'd0);
        check("abort ready", 32'(bus_if.ready), 32'd1);
        rst = 1'b0;
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus_if.done) cnt++;
        end
        check("abort no done", 32'(cnt), 32'd0);

        for (int i = 0; i < 200; i++) begin
            d = $urandom;
            a = 5'($urandom);
            c = 1'($urandom);
            m = 2'($urandom);
            if ($urandom_range(0, 3) != 0) repeat ($urandom_range(1, 3)) @(negedge clk);
            do_op(d, a, c, m, ref_shift(d, int'(a), c, m), cyc(int'(a)) + 1, 1'b0, "rand");
        end
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
